// File: rtl/tl_pkg.sv
// TileLink support package: channel opcodes, beat-count helpers and the
// outstanding-limiter drain state encoding.
//   TL_SZW            width of every *_size field (log2 bytes)
//   tl_num_beats()    beats in a data-bearing message of a given size
//   tl_a/d_has_data() which opcodes carry a data payload
package tl_pkg;

   localparam int TL_SZW = 4;

   typedef logic [2:0] tl_op_t;

   // A channel
   localparam tl_op_t PUT_FULL_DATA    = 3'd0;
   localparam tl_op_t PUT_PARTIAL_DATA = 3'd1;
   localparam tl_op_t ARITHMETIC_DATA  = 3'd2;
   localparam tl_op_t LOGICAL_DATA     = 3'd3;
   localparam tl_op_t GET              = 3'd4;
   localparam tl_op_t INTENT           = 3'd5;
   localparam tl_op_t ACQUIRE_BLOCK    = 3'd6;
   localparam tl_op_t ACQUIRE_PERM     = 3'd7;

   // D channel
   localparam tl_op_t ACCESS_ACK       = 3'd0;
   localparam tl_op_t ACCESS_ACK_DATA  = 3'd1;
   localparam tl_op_t HINT_ACK         = 3'd2;
   localparam tl_op_t GRANT            = 3'd4;
   localparam tl_op_t GRANT_DATA       = 3'd5;
   localparam tl_op_t RELEASE_ACK      = 3'd6;

   typedef enum logic [1:0] {RUN, DRAIN, DRAINED} limiter_state_e;

   // Messages no wider than one beat still take a single beat.
   function automatic int unsigned tl_num_beats(input logic [TL_SZW-1:0] size,
                                                input int unsigned beat_bytes);
      int unsigned lg;
      lg = $clog2(beat_bytes);
      if (32'(size) <= lg) return 32'd1;
      return 32'd1 << (32'(size) - lg);
   endfunction

   function automatic logic tl_a_has_data(input tl_op_t op);
      return op < GET;
   endfunction

   function automatic logic tl_d_has_data(input tl_op_t op);
      return (op == ACCESS_ACK_DATA) || (op == GRANT_DATA);
   endfunction

endpackage

// File: rtl/TL_BUS.sv
// TileLink link bundle (channels A..E).
// Modports are named for what the port connects to:
//   Master  port facing a master: receives A/C/E requests, returns B/D
//   Slave   port facing a slave:  drives A/C/E, receives B/D
interface TL_BUS #(
   parameter int DW    = 64,
   parameter int AW    = 32,
   parameter int SRCW  = 4,
   parameter int SINKW = 4
);
   localparam int SZW = tl_pkg::TL_SZW;

   logic               a_valid, a_ready, a_corrupt;
   tl_pkg::tl_op_t     a_opcode;
   logic [2:0]         a_param;
   logic [SZW-1:0]     a_size;
   logic [SRCW-1:0]    a_source;
   logic [AW-1:0]      a_address;
   logic [DW/8-1:0]    a_mask;
   logic [DW-1:0]      a_data;

   logic               b_valid, b_ready;
   tl_pkg::tl_op_t     b_opcode;
   logic [2:0]         b_param;
   logic [SZW-1:0]     b_size;
   logic [SRCW-1:0]    b_source;
   logic [AW-1:0]      b_address;

   logic               c_valid, c_ready;
   tl_pkg::tl_op_t     c_opcode;
   logic [2:0]         c_param;
   logic [SZW-1:0]     c_size;
   logic [SRCW-1:0]    c_source;
   logic [AW-1:0]      c_address;
   logic [DW-1:0]      c_data;

   logic               d_valid, d_ready, d_denied, d_corrupt;
   tl_pkg::tl_op_t     d_opcode;
   logic [1:0]         d_param;
   logic [SZW-1:0]     d_size;
   logic [SRCW-1:0]    d_source;
   logic [SINKW-1:0]   d_sink;
   logic [DW-1:0]      d_data;

   logic               e_valid, e_ready;
   logic [SINKW-1:0]   e_sink;

   modport Master (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      output a_ready,
      output b_valid, b_opcode, b_param, b_size, b_source, b_address,
      input  b_ready,
      input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
      output c_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
      input  d_ready,
      input  e_valid, e_sink,
      output e_ready
   );

   modport Slave (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      input  a_ready,
      input  b_valid, b_opcode, b_param, b_size, b_source, b_address,
      output b_ready,
      output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
      input  c_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
      output d_ready,
      output e_valid, e_sink,
      input  e_ready
   );
endinterface

// File: rtl/tl_beat_counter.sv
// Tracks the beat position inside a (possibly multi-beat) TL message.
//   clk_i, rst_i  clock, async active-high reset
//   fire          a beat transfers this cycle
//   size          log2 bytes of the message in flight
//   has_data      message carries data (otherwise it is a single beat)
//   first         current beat is the first of its message
//   last          current beat is the last of its message
module tl_beat_counter
   import tl_pkg::*;
#(
   parameter int BEAT_BYTES    = 8,
   parameter int MAX_SIZE_LOG2 = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              fire,
   input  logic [TL_SZW-1:0] size,
   input  logic              has_data,
   output logic              first,
   output logic              last
);
   localparam int MAX_BEATS = ((1 << MAX_SIZE_LOG2) > BEAT_BYTES) ?
                              (1 << MAX_SIZE_LOG2) / BEAT_BYTES : 1;
   localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   logic [CW-1:0] beat;
   int unsigned   beats;

   assign beats = has_data ? tl_num_beats(size, BEAT_BYTES) : 32'd1;
   assign first = (beat == '0);
   assign last  = (32'(beat) == beats - 32'd1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     beat <= '0;
      else if (fire) beat <= last ? '0 : beat + CW'(1);
   end
endmodule

// File: rtl/tl_outstanding_limiter.sv
// Caps the number of in-flight A-channel transactions and offers a drain
// handshake. Everything except A valid/ready passes straight through.
//   clk_i, rst_i   clock, async active-high reset
//   in             link from the master
//   out            link to the first buffer stage
//   drain_req_i    level; stop admitting new A messages while high
//   drained_o      drain requested and nothing left in flight
//   outstanding_o  transactions currently in flight
//   err_o          one-cycle pulse on a D response with nothing in flight
module tl_outstanding_limiter
   import tl_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int BEAT_BYTES      = 8,
   parameter int MAX_SIZE_LOG2   = 6,
   localparam int CNTW           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   TL_BUS.Master           in,
   TL_BUS.Slave            out,
   input  logic            drain_req_i,
   output logic            drained_o,
   output logic [CNTW-1:0] outstanding_o,
   output logic            err_o
);
   limiter_state_e  state_q, state_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            err_q, underflow;
   logic            a_first, a_last, a_fire, a_idle_next, block;
   logic            d_first_unused, d_last, d_fire;
   logic            inc, dec;

   // ---- pass-through ----
   assign out.a_opcode  = in.a_opcode;
   assign out.a_param   = in.a_param;
   assign out.a_size    = in.a_size;
   assign out.a_source  = in.a_source;
   assign out.a_address = in.a_address;
   assign out.a_mask    = in.a_mask;
   assign out.a_data    = in.a_data;
   assign out.a_corrupt = in.a_corrupt;

   assign in.b_valid    = out.b_valid;
   assign in.b_opcode   = out.b_opcode;
   assign in.b_param    = out.b_param;
   assign in.b_size     = out.b_size;
   assign in.b_source   = out.b_source;
   assign in.b_address  = out.b_address;
   assign out.b_ready   = in.b_ready;

   assign out.c_valid   = in.c_valid;
   assign out.c_opcode  = in.c_opcode;
   assign out.c_param   = in.c_param;
   assign out.c_size    = in.c_size;
   assign out.c_source  = in.c_source;
   assign out.c_address = in.c_address;
   assign out.c_data    = in.c_data;
   assign in.c_ready    = out.c_ready;

   assign in.d_valid    = out.d_valid;
   assign in.d_opcode   = out.d_opcode;
   assign in.d_param    = out.d_param;
   assign in.d_size     = out.d_size;
   assign in.d_source   = out.d_source;
   assign in.d_sink     = out.d_sink;
   assign in.d_denied   = out.d_denied;
   assign in.d_data     = out.d_data;
   assign in.d_corrupt  = out.d_corrupt;
   assign out.d_ready   = in.d_ready;

   assign out.e_valid   = in.e_valid;
   assign out.e_sink    = in.e_sink;
   assign in.e_ready    = out.e_ready;

   // ---- A gating: only first beats are ever held back ----
   assign block       = a_first && ((count_q == CNTW'(MAX_OUTSTANDING)) || (state_q != RUN));
   assign out.a_valid = in.a_valid && !block;
   assign in.a_ready  = out.a_ready && !block;
   assign a_fire      = in.a_valid && in.a_ready;
   assign d_fire      = out.d_valid && in.d_ready;

   tl_beat_counter #(.BEAT_BYTES(BEAT_BYTES), .MAX_SIZE_LOG2(MAX_SIZE_LOG2)) u_a_beats (
      .clk_i(clk_i), .rst_i(rst_i), .fire(a_fire), .size(in.a_size),
      .has_data(tl_a_has_data(in.a_opcode)), .first(a_first), .last(a_last));

   // The D side only needs the last beat.
   tl_beat_counter #(.BEAT_BYTES(BEAT_BYTES), .MAX_SIZE_LOG2(MAX_SIZE_LOG2)) u_d_beats (
      .clk_i(clk_i), .rst_i(rst_i), .fire(d_fire), .size(out.d_size),
      .has_data(tl_d_has_data(out.d_opcode)), .first(d_first_unused), .last(d_last));

   // A beat position returns to zero after this edge.
   assign a_idle_next = a_fire ? a_last : a_first;

   // ReleaseAck answers C traffic, so it never retires an A transaction.
   assign inc = a_fire && a_first;
   assign dec = d_fire && d_last &&
                (out.d_opcode inside {ACCESS_ACK, ACCESS_ACK_DATA, HINT_ACK, GRANT, GRANT_DATA});

   always_comb begin
      count_d   = count_q;
      underflow = 1'b0;
      if (inc && !dec) begin
         count_d = count_q + CNTW'(1);
      end else if (dec && !inc) begin
         if (count_q == '0) underflow = 1'b1;
         else               count_d   = count_q - CNTW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (drain_req_i) state_d = DRAIN;
         DRAIN:   if (!drain_req_i) state_d = RUN;
                  else if (count_d == '0 && a_idle_next) state_d = DRAINED;
         DRAINED: if (!drain_req_i) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RUN;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         err_q   <= underflow;
      end
   end

   assign drained_o     = (state_q == DRAINED);
   assign outstanding_o = count_q;
   assign err_o         = err_q;
endmodule

// File: tb/tb_tl_outstanding_limiter.sv
module tb_tl_outstanding_limiter;
   import tl_pkg::*;

   typedef struct {
      string      nm;
      logic [6:0] exp;   // {out.a_valid, in.a_ready, in.d_valid, count[1:0], err, drained}
   } st_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [3:0]  sz;
      logic [31:0] addr;
      logic [63:0] data;
   } abeat_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       drain;
   logic       drained, err;
   logic [1:0] cnt;
   int         n_vec = 0;
   int         n_err = 0;

   st_t    st_q[$];
   abeat_t a_q[$];

   TL_BUS #(.DW(64)) in_bus();
   TL_BUS #(.DW(64)) out_bus();

   tl_outstanding_limiter #(.MAX_OUTSTANDING(2), .BEAT_BYTES(8), .MAX_SIZE_LOG2(6)) dut (
      .clk_i(clk), .rst_i(rst), .in(in_bus), .out(out_bus), .drain_req_i(drain),
      .drained_o(drained), .outstanding_o(cnt), .err_o(err));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit, vectors=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   // Monitor: compares whatever the DUT presents against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (out_bus.a_valid && out_bus.a_ready) begin
         abeat_t act, ex;
         act = '{out_bus.a_opcode, out_bus.a_size, out_bus.a_address, out_bus.a_data};
         n_vec++;
         if (a_q.size() == 0) begin
            n_err++;
            $display("FAIL a_beat_unexpected: got %h, required none", act);
         end else begin
            ex = a_q.pop_front();
            if (act !== ex) begin
               n_err++;
               $display("FAIL a_beat: got %h, required %h", act, ex);
            end
         end
      end
      if (st_q.size() != 0) begin
         st_t        se;
         logic [6:0] act;
         se  = st_q.pop_front();
         act = {out_bus.a_valid, in_bus.a_ready, in_bus.d_valid, cnt, err, drained};
         n_vec++;
         if (act !== se.exp) begin
            n_err++;
            $display("FAIL %s: got av/ar/dv/cnt/err/drn=%b, required %b", se.nm, act, se.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input tl_op_t op, input logic [3:0] sz,
                        input logic [31:0] addr, input logic [63:0] data);
      in_bus.a_valid   = v;
      in_bus.a_opcode  = op;
      in_bus.a_size    = sz;
      in_bus.a_address = addr;
      in_bus.a_data    = data;
   endtask

   task automatic drv_d(input logic v, input tl_op_t op, input logic [3:0] sz);
      out_bus.d_valid  = v;
      out_bus.d_opcode = op;
      out_bus.d_size   = sz;
   endtask

   // Expect the currently driven A beat to appear downstream.
   task automatic exp_a();
      a_q.push_back('{in_bus.a_opcode, in_bus.a_size, in_bus.a_address, in_bus.a_data});
   endtask

   task automatic cyc(input string nm, input logic av, input logic ar, input logic [1:0] c,
                      input logic e, input logic dr);
      st_q.push_back('{nm, {av, ar, out_bus.d_valid, c, e, dr}});
      tick();
   endtask

   initial begin
      rst = 1'b1;
      drain = 1'b0;
      drv_a(0, GET, 0, 0, 0);
      in_bus.a_param = '0;  in_bus.a_source = '0;  in_bus.a_mask = '1;  in_bus.a_corrupt = 1'b0;
      in_bus.b_ready = 1'b1;  in_bus.d_ready = 1'b1;
      in_bus.c_valid = 1'b0;  in_bus.c_opcode = '0;  in_bus.c_param = '0;  in_bus.c_size = '0;
      in_bus.c_source = '0;  in_bus.c_address = '0;  in_bus.c_data = '0;
      in_bus.e_valid = 1'b0;  in_bus.e_sink = '0;
      out_bus.a_ready = 1'b1;  out_bus.c_ready = 1'b1;  out_bus.e_ready = 1'b1;
      out_bus.b_valid = 1'b0;  out_bus.b_opcode = '0;  out_bus.b_param = '0;  out_bus.b_size = '0;
      out_bus.b_source = '0;  out_bus.b_address = '0;
      drv_d(0, ACCESS_ACK, 0);
      out_bus.d_param = '0;  out_bus.d_source = '0;  out_bus.d_sink = '0;
      out_bus.d_denied = 1'b0;  out_bus.d_data = '0;  out_bus.d_corrupt = 1'b0;

      tick();
      cyc("reset", 0, 1, 0, 0, 0);
      rst = 1'b0;

      // Limit of 2 with responses held off
      out_bus.a_ready = 1'b0;
      drv_a(1, GET, 3, 32'h0F8, 0);             cyc("a_ready_low", 1, 0, 0, 0, 0);
      out_bus.a_ready = 1'b1;
      drv_a(1, GET, 3, 32'h100, 0); exp_a();    cyc("get1", 1, 1, 0, 0, 0);
      drv_a(1, GET, 3, 32'h108, 0); exp_a();    cyc("get2", 1, 1, 1, 0, 0);
      drv_a(1, GET, 3, 32'h110, 0);             cyc("get3_blocked", 0, 0, 2, 0, 0);
      drv_d(1, ACCESS_ACK_DATA, 3);             cyc("ack_while_full", 0, 0, 2, 0, 0);
      drv_d(0, ACCESS_ACK, 0); exp_a();         cyc("get3_released", 1, 1, 1, 0, 0);
      drv_a(0, GET, 0, 0, 0);
      drv_d(1, ACCESS_ACK_DATA, 3);             cyc("full_ack1", 0, 0, 2, 0, 0);
                                                cyc("full_ack2", 0, 1, 1, 0, 0);
      drv_d(0, ACCESS_ACK, 0);                  cyc("t1_empty", 0, 1, 0, 0, 0);

      // 8-beat PutFull counts once
      for (int b = 0; b < 8; b++) begin
         drv_a(1, PUT_FULL_DATA, 6, 32'h200, 64'(b)); exp_a();
         cyc("put8_beat", 1, 1, (b == 0) ? 2'd0 : 2'd1, 0, 0);
      end
      drv_a(0, GET, 0, 0, 0);
      drv_d(1, ACCESS_ACK, 6);                  cyc("put8_ack", 0, 1, 1, 0, 0);
      drv_d(0, ACCESS_ACK, 0);                  cyc("put8_done", 0, 1, 0, 0, 0);

      // 8-beat AccessAckData retires on its last beat only
      drv_a(1, GET, 6, 32'h300, 0); exp_a();    cyc("get64", 1, 1, 0, 0, 0);
      drv_a(0, GET, 0, 0, 0);
      for (int b = 0; b < 8; b++) begin
         drv_d(1, ACCESS_ACK_DATA, 6);          cyc("get64_dbeat", 0, 1, 1, 0, 0);
      end
      drv_d(0, ACCESS_ACK, 0);                  cyc("get64_done", 0, 1, 0, 0, 0);

      // Simultaneous increment and decrement
      drv_a(1, GET, 3, 32'h400, 0); exp_a();    cyc("t4_get", 1, 1, 0, 0, 0);
      drv_a(1, GET, 3, 32'h408, 0); exp_a();
      drv_d(1, ACCESS_ACK_DATA, 3);             cyc("t4_inc_dec", 1, 1, 1, 0, 0);
      drv_a(0, GET, 0, 0, 0);
      drv_d(0, ACCESS_ACK, 0);                  cyc("t4_hold", 0, 1, 1, 0, 0);
      drv_d(1, ACCESS_ACK_DATA, 3);             cyc("t4_ack", 0, 1, 1, 0, 0);
      drv_d(0, ACCESS_ACK, 0);                  cyc("t4_empty", 0, 1, 0, 0, 0);

      // ReleaseAck ignored, orphan AccessAck flags error for one cycle
      drv_d(1, RELEASE_ACK, 3);                 cyc("relack", 0, 1, 0, 0, 0);
      drv_d(0, ACCESS_ACK, 0);                  cyc("relack_noerr", 0, 1, 0, 0, 0);
      drv_d(1, ACCESS_ACK, 3);                  cyc("orphan_ack", 0, 1, 0, 0, 0);
      drv_d(0, ACCESS_ACK, 0);                  cyc("err_pulse", 0, 1, 0, 1, 0);
                                                cyc("err_clear", 0, 1, 0, 0, 0);

      // Drain raised mid-burst
      drv_a(1, GET, 3, 32'h500, 0); exp_a();    cyc("t6_get", 1, 1, 0, 0, 0);
      for (int b = 0; b < 4; b++) begin
         if (b == 1) drain = 1'b1;
         drv_a(1, PUT_FULL_DATA, 5, 32'h600, 64'(b)); exp_a();
         cyc("t6_put_beat", 1, 1, (b == 0) ? 2'd1 : 2'd2, 0, 0);
      end
      drv_a(1, GET, 3, 32'h700, 0);             cyc("t6_get_blocked", 0, 0, 2, 0, 0);
      drv_d(1, ACCESS_ACK_DATA, 3);             cyc("t6_ack_get", 0, 0, 2, 0, 0);
      drv_d(1, ACCESS_ACK, 5);                  cyc("t6_ack_put", 0, 0, 1, 0, 0);
      drv_d(0, ACCESS_ACK, 0);                  cyc("t6_drained", 0, 0, 0, 0, 1);
      drain = 1'b0;                             cyc("t6_undrain", 0, 0, 0, 0, 1);
      exp_a();                                  cyc("t6_get_ok", 1, 1, 0, 0, 0);
      drv_a(0, GET, 0, 0, 0);
      drv_d(1, ACCESS_ACK_DATA, 3);             cyc("t6_ack", 0, 1, 1, 0, 0);
      drv_d(0, ACCESS_ACK, 0);                  cyc("t6_idle", 0, 1, 0, 0, 0);

      // Reset forgets in-flight work; late response is an error
      drv_a(1, GET, 3, 32'h800, 0); exp_a();    cyc("t7_get", 1, 1, 0, 0, 0);
      drv_a(0, GET, 0, 0, 0);
      rst = 1'b1;                               cyc("t7_reset", 0, 1, 0, 0, 0);
      rst = 1'b0;
      drv_d(1, ACCESS_ACK_DATA, 3);             cyc("t7_orphan", 0, 1, 0, 0, 0);
      drv_d(0, ACCESS_ACK, 0);                  cyc("t7_err", 0, 1, 0, 1, 0);
                                                cyc("t7_clear", 0, 1, 0, 0, 0);

      for (int i = 0; i < 5 && (st_q.size() != 0 || a_q.size() != 0); i++) tick();
      if (st_q.size() != 0 || a_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_queues: got %0d status and %0d beats pending, required 0",
                  st_q.size(), a_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
